// File: rtl/seg7_pkg.sv
// seg7_pkg: shared segment lookup, FSM state type and blank pattern for the 7-segment shift driver.
package seg7_pkg;
   localparam logic [6:0] SEG7_HEX_LUT [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };
   typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DONE} state_t;
   localparam logic [7:0] SEG7_BLANK = 8'hFF;
endpackage

// File: rtl/seg7_hex_encode.sv
// seg7_hex_encode: nibble plus decimal point to active-low {dp,g,f,e,d,c,b,a} byte.
module seg7_hex_encode
   import seg7_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       dp,
   output logic [7:0] seg
);
   always_comb seg = ~{dp, SEG7_HEX_LUT[nibble]};
endmodule

// File: rtl/seg7_shift_driver.sv
// seg7_shift_driver: serial frame driver for chained 74HC595 7-segment digits.
// Optional per-digit blinking is enabled by defining SEG7_BLINK_EN.
module seg7_shift_driver
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS = 8,
   parameter int CLK_DIV = 4
`ifdef SEG7_BLINK_EN
   , parameter int BLINK_FRAMES = 32
`endif
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    mode,
   input  logic [4*NUM_DIGITS-1:0] hex_data,
   input  logic [NUM_DIGITS-1:0]   points,
   input  logic [8*NUM_DIGITS-1:0] pixel,
`ifdef SEG7_BLINK_EN
   input  logic [NUM_DIGITS-1:0]   blink,
`endif
   output logic                    sh_clk,
   output logic                    sh_data,
   output logic                    sh_latch,
   output logic                    busy,
   output logic                    done
);
   localparam int W = 8*NUM_DIGITS;
   localparam int DW = $clog2(2*CLK_DIV+1);
   localparam int BW = $clog2(W+1);
   localparam logic [DW-1:0] DIV_LAST = DW'(2*CLK_DIV-1);
   localparam logic [DW-1:0] HALF_LAST = DW'(CLK_DIV-1);
   localparam logic [BW-1:0] BIT_LAST = BW'(W-1);

   state_t state, state_n;
   logic [DW-1:0] div_cnt;
   logic [BW-1:0] bit_cnt;
   logic [W-1:0] frame_q, frame_d, hex_bytes;
   logic div_end;

`ifdef SEG7_BLINK_EN
   localparam int FW = $clog2(BLINK_FRAMES)+1;
   localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES-1);
   logic [FW-1:0] frame_cnt;
   logic blink_off;
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_cnt <= '0;
         blink_off <= 1'b0;
      end else if (state == DONE) begin
         frame_cnt <= frame_cnt == FRAME_LAST ? '0 : frame_cnt + 1'b1;
         if (frame_cnt == FRAME_LAST) blink_off <= ~blink_off;
      end
   end
`endif

   for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
      logic [7:0] raw;
      seg7_hex_encode u_enc (.nibble(hex_data[4*i+:4]), .dp(points[i]), .seg(hex_bytes[8*i+:8]));
      assign raw = mode ? pixel[8*i+:8] : hex_bytes[8*i+:8];
`ifdef SEG7_BLINK_EN
      assign frame_d[8*i+:8] = (blink_off && blink[i]) ? SEG7_BLANK : raw;
`else
      assign frame_d[8*i+:8] = raw;
`endif
   end

   // div_cnt spans a full bit (low+high half) in SHIFT, one half-period in LATCH
   always_comb begin
      div_end = state == SHIFT ? div_cnt == DIV_LAST : div_cnt == HALF_LAST;
      state_n = state;
      case (state)
         IDLE:    state_n = start ? SHIFT : IDLE;
         SHIFT:   state_n = (div_end && bit_cnt == BIT_LAST) ? LATCH : SHIFT;
         LATCH:   state_n = div_end ? DONE : LATCH;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         div_cnt <= '0;
         bit_cnt <= '0;
         frame_q <= '0;
      end else begin
         state <= state_n;
         if (state == IDLE && start) begin
            frame_q <= frame_d;
            div_cnt <= '0;
            bit_cnt <= '0;
         end else if (state == SHIFT || state == LATCH) begin
            div_cnt <= div_end ? '0 : div_cnt + 1'b1;
            if (state == SHIFT && div_end) begin
               bit_cnt <= bit_cnt + 1'b1;
               frame_q <= {frame_q[W-2:0], 1'b0};
            end
         end
      end
   end

   always_comb begin
      sh_clk   = state == SHIFT && div_cnt > HALF_LAST;
      sh_data  = state == SHIFT && frame_q[W-1];
      sh_latch = state == LATCH;
      busy     = state == SHIFT || state == LATCH;
      done     = state == DONE;
   end
endmodule
